hack_keyboard: RTL

HACK_KEYBOARD -- requirements
Module: hack_keyboard

---
 rtl/hack_keyboard.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hack_keyboard.sv
// hack_keyboard: turns hps_io PS/2 set-2 key events into the Hack keyboard register value (0x6000).
// Define HACK_KBD_CAPSLOCK_EN to enable caps-lock on scancode 0x58; otherwise caps_on is tied to 0.
module hack_keyboard #(
  parameter int CLR_ON_RELEASE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [15:0] key_code,
  output logic        key_strobe,
  output logic        caps_on
);

  logic       r_toggle;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_held_vld;
  logic [8:0] r_held_id;
  logic [7:0] r_code;
  logic       r_strobe;

  logic       w_event;
  logic       w_pressed;
  logic       w_ext;
  logic [7:0] w_sc;
  logic       w_shift;
  logic       w_upper;
  logic [8:0] w_map;

  // Returns {mapped, ascii}. Letters follow the case flag, everything else follows shift only.
  function automatic logic [8:0] f_translate(input logic ext, input logic [7:0] sc,
                                             input logic shift, input logic upper);
    logic [7:0] v_lo;
    logic [7:0] v_hi;
    logic [8:0] v_res;
    v_lo  = 8'd0;
    v_hi  = 8'd0;
    v_res = 9'd0;
    if (ext) begin
      case (sc)
        8'h6B: v_lo = 8'd130;  8'h75: v_lo = 8'd131;
        8'h74: v_lo = 8'd132;  8'h72: v_lo = 8'd133;
        8'h6C: v_lo = 8'd134;  8'h69: v_lo = 8'd135;
        8'h7D: v_lo = 8'd136;  8'h7A: v_lo = 8'd137;
        8'h70: v_lo = 8'd138;  8'h71: v_lo = 8'd139;
        default: v_lo = 8'd0;
      endcase
      v_res = {(v_lo != 8'd0), v_lo};
    end else begin
      case (sc)
        8'h1C: v_lo = "a";  8'h32: v_lo = "b";  8'h21: v_lo = "c";  8'h23: v_lo = "d";
        8'h24: v_lo = "e";  8'h2B: v_lo = "f";  8'h34: v_lo = "g";  8'h33: v_lo = "h";
        8'h43: v_lo = "i";  8'h3B: v_lo = "j";  8'h42: v_lo = "k";  8'h4B: v_lo = "l";
        8'h3A: v_lo = "m";  8'h31: v_lo = "n";  8'h44: v_lo = "o";  8'h4D: v_lo = "p";
        8'h15: v_lo = "q";  8'h2D: v_lo = "r";  8'h1B: v_lo = "s";  8'h2C: v_lo = "t";
        8'h3C: v_lo = "u";  8'h2A: v_lo = "v";  8'h1D: v_lo = "w";  8'h22: v_lo = "x";
        8'h35: v_lo = "y";  8'h1A: v_lo = "z";
        8'h16: begin v_lo = "1"; v_hi = "!"; end
        8'h1E: begin v_lo = "2"; v_hi = "@"; end
        8'h26: begin v_lo = "3"; v_hi = "#"; end
        8'h25: begin v_lo = "4"; v_hi = "$"; end
        8'h2E: begin v_lo = "5"; v_hi = "%"; end
        8'h36: begin v_lo = "6"; v_hi = "^"; end
        8'h3D: begin v_lo = "7"; v_hi = "&"; end
        8'h3E: begin v_lo = "8"; v_hi = "*"; end
        8'h46: begin v_lo = "9"; v_hi = "("; end
        8'h45: begin v_lo = "0"; v_hi = ")"; end
        8'h4E: begin v_lo = "-"; v_hi = "_"; end
        8'h55: begin v_lo = "="; v_hi = "+"; end
        8'h54: begin v_lo = "["; v_hi = "{"; end
        8'h5B: begin v_lo = "]"; v_hi = "}"; end
        8'h5D: begin v_lo = 8'd92; v_hi = "|"; end
        8'h4C: begin v_lo = ";"; v_hi = ":"; end
        8'h52: begin v_lo = "'"; v_hi = 8'd34; end
        8'h41: begin v_lo = ","; v_hi = "<"; end
        8'h49: begin v_lo = "."; v_hi = ">"; end
        8'h4A: begin v_lo = "/"; v_hi = "?"; end
        8'h29: v_lo = 8'd32;
        8'h5A: v_lo = 8'd128;  8'h66: v_lo = 8'd129;  8'h76: v_lo = 8'd140;
        8'h05: v_lo = 8'd141;  8'h06: v_lo = 8'd142;  8'h04: v_lo = 8'd143;
        8'h0C: v_lo = 8'd144;  8'h03: v_lo = 8'd145;  8'h0B: v_lo = 8'd146;
        8'h83: v_lo = 8'd147;  8'h0A: v_lo = 8'd148;  8'h01: v_lo = 8'd149;
        8'h09: v_lo = 8'd150;  8'h78: v_lo = 8'd151;  8'h07: v_lo = 8'd152;
        default: v_lo = 8'd0;
      endcase
      if (v_lo >= "a" && v_lo <= "z")
        v_res = {1'b1, (upper ? v_lo - 8'd32 : v_lo)};
      else if (shift && v_hi != 8'd0)
        v_res = {1'b1, v_hi};
      else
        v_res = {(v_lo != 8'd0), v_lo};
    end
    return v_res;
  endfunction

  assign w_event   = ps2_key[10] ^ r_toggle;
  assign w_pressed = ps2_key[9];
  assign w_ext     = ps2_key[8];
  assign w_sc      = ps2_key[7:0];
  assign w_shift   = r_lshift | r_rshift;
  assign w_upper   = w_shift ^ caps_on;
  assign w_map     = f_translate(w_ext, w_sc, w_shift, w_upper);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_toggle   <= ps2_key[10];
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_held_vld <= 1'b0;
      r_held_id  <= 9'd0;
      r_code     <= 8'd0;
      r_strobe   <= 1'b0;
    end else begin
      r_toggle <= ps2_key[10];
      r_strobe <= 1'b0;
      if (w_event) begin
        if (!w_ext && w_sc == 8'h12) r_lshift <= w_pressed;
        if (!w_ext && w_sc == 8'h59) r_rshift <= w_pressed;
        if (w_pressed && w_map[8]) begin
          r_code     <= w_map[7:0];
          r_held_vld <= 1'b1;
          r_held_id  <= {w_ext, w_sc};
          r_strobe   <= 1'b1;
        end else if (!w_pressed && CLR_ON_RELEASE != 0 && r_held_vld &&
                     r_held_id == {w_ext, w_sc}) begin
          r_code     <= 8'd0;
          r_held_vld <= 1'b0;
        end
      end
    end
  end

`ifdef HACK_KBD_CAPSLOCK_EN
  logic r_caps;
  always_ff @(posedge clk) begin
    if (reset)
      r_caps <= 1'b0;
    else if (w_event && w_pressed && !w_ext && w_sc == 8'h58)
      r_caps <= ~r_caps;
  end
  assign caps_on = r_caps;
`else
  assign caps_on = 1'b0;
`endif

  assign key_code   = {8'd0, r_code};
  assign key_strobe = r_strobe;

endmodule
